// File: rtl/instr_retire_merger.sv
`default_nettype none
// ============================================================================
// instr_retire_merger : four per-lane FIFOs merged round-robin onto one
//                       registered host stream, with lane tag and retire count
// Revision 1.0
// ============================================================================
module instr_retire_merger #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_a,
  output logic             in_ready_a,
  input  logic [WIDTH-1:0] in_instr_a,
  input  logic             in_valid_b,
  output logic             in_ready_b,
  input  logic [WIDTH-1:0] in_instr_b,
  input  logic             in_valid_c,
  output logic             in_ready_c,
  input  logic [WIDTH-1:0] in_instr_c,
  input  logic             in_valid_d,
  output logic             in_ready_d,
  input  logic [WIDTH-1:0] in_instr_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [1:0]       out_lane,
  output logic [31:0]      retire_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [3:0]       lane_valid;
  logic [3:0]       lane_ready;
  logic [3:0]       lane_not_empty;
  logic [3:0]       lane_pop;
  logic [WIDTH-1:0] lane_instr [4];
  logic [WIDTH-1:0] lane_head  [4];

  assign lane_valid    = {in_valid_d, in_valid_c, in_valid_b, in_valid_a};
  assign lane_instr[0] = in_instr_a;
  assign lane_instr[1] = in_instr_b;
  assign lane_instr[2] = in_instr_c;
  assign lane_instr[3] = in_instr_d;

  assign in_ready_a = lane_ready[0];
  assign in_ready_b = lane_ready[1];
  assign in_ready_c = lane_ready[2];
  assign in_ready_d = lane_ready[3];

  // Ready comes from registered occupancy only, so a full FIFO popped this
  // cycle still refuses a push until the next cycle.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             push;

    assign lane_ready[i]     = (cnt_q != C_FULL);
    assign lane_not_empty[i] = (cnt_q != '0);
    assign push              = lane_valid[i] && lane_ready[i];
    assign lane_head[i]      = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push)        wr_q <= wr_q + 1'b1;
        if (lane_pop[i]) rd_q <= rd_q + 1'b1;
        case ({push, lane_pop[i]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= lane_instr[i];
    end
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_instr_q, out_instr_d;
  logic [1:0]       out_lane_q,  out_lane_d;
  logic [1:0]       last_q,      last_d;
  logic [31:0]      count_q,     count_d;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             any_ready;
  logic             load;

  always_comb begin
    grant     = last_q;
    any_ready = 1'b0;
    idx       = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!any_ready && lane_not_empty[idx]) begin
        grant     = idx;
        any_ready = 1'b1;
      end
    end
  end

  assign load     = (!out_valid_q || out_ready) && any_ready;
  assign lane_pop = load ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_lane_d  = out_lane_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = lane_head[grant];
      out_lane_d  = grant;
      last_d      = grant;
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = 1'b0;
    end
    count_d = count_q + ((out_valid_q && out_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_lane_q  <= 2'd0;
      last_q      <= 2'd3;
      count_q     <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_lane_q  <= out_lane_d;
      last_q      <= last_d;
      count_q     <= count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_lane     = out_lane_q;
  assign retire_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_retire_merger.sv
`default_nettype none
// ============================================================================
// tb_instr_retire_merger : directed self-checking bench for instr_retire_merger
// Revision 1.0
// ============================================================================
module tb_instr_retire_merger;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid_a = 1'b0, in_valid_b = 1'b0, in_valid_c = 1'b0, in_valid_d = 1'b0;
  logic             in_ready_a, in_ready_b, in_ready_c, in_ready_d;
  logic [WIDTH-1:0] in_instr_a = '0, in_instr_b = '0, in_instr_c = '0, in_instr_d = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_instr;
  logic [1:0]       out_lane;
  logic [31:0]      retire_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_retire_merger #(.WIDTH(WIDTH), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_a   (in_valid_a),
    .in_ready_a   (in_ready_a),
    .in_instr_a   (in_instr_a),
    .in_valid_b   (in_valid_b),
    .in_ready_b   (in_ready_b),
    .in_instr_b   (in_instr_b),
    .in_valid_c   (in_valid_c),
    .in_ready_c   (in_ready_c),
    .in_instr_c   (in_instr_c),
    .in_valid_d   (in_valid_d),
    .in_ready_d   (in_ready_d),
    .in_instr_d   (in_instr_d),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_lane     (out_lane),
    .retire_count (retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_lane", 32'(out_lane), 32'd0);
    chk("rst_count", retire_count, 32'd0);
    chk("rst_ready_all", 32'({in_ready_d, in_ready_c, in_ready_b, in_ready_a}), 32'hF);

    // Single beat from lane c
    out_ready  = 1'b1;
    in_valid_c = 1'b1;
    in_instr_c = 32'h4000_0001;
    step();
    in_valid_c = 1'b0;
    chk("t1_no_bypass", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", out_instr, 32'h4000_0001);
    chk("t1_lane", 32'(out_lane), 32'd2);
    step();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_count", retire_count, 32'd1);
    chk("t1_instr_hold", out_instr, 32'h4000_0001);

    // Four lanes pushing at the same edge
    do_reset();
    out_ready  = 1'b1;
    in_valid_a = 1'b1; in_instr_a = 32'h0000_000A;
    in_valid_b = 1'b1; in_instr_b = 32'h2000_000B;
    in_valid_c = 1'b1; in_instr_c = 32'h4000_000C;
    in_valid_d = 1'b1; in_instr_d = 32'h6000_000D;
    step();
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0; in_valid_d = 1'b0;
    step();
    chk("t2_lane0", 32'(out_lane), 32'd0);
    chk("t2_instr0", out_instr, 32'h0000_000A);
    step();
    chk("t2_lane1", 32'(out_lane), 32'd1);
    chk("t2_instr1", out_instr, 32'h2000_000B);
    step();
    chk("t2_lane2", 32'(out_lane), 32'd2);
    chk("t2_instr2", out_instr, 32'h4000_000C);
    step();
    chk("t2_lane3", 32'(out_lane), 32'd3);
    chk("t2_instr3", out_instr, 32'h6000_000D);
    chk("t2_valid3", 32'(out_valid), 32'd1);
    step();
    chk("t2_valid_end", 32'(out_valid), 32'd0);
    chk("t2_count", retire_count, 32'd4);

    // Fairness between continuously valid lanes a and c
    do_reset();
    out_ready  = 1'b1;
    in_valid_a = 1'b1; in_instr_a = 32'h0000_0AAA;
    in_valid_c = 1'b1; in_instr_c = 32'h4000_0CCC;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_lane", 32'(out_lane), (i % 2 == 0) ? 32'd0 : 32'd2);
    end
    in_valid_a = 1'b0;
    in_valid_c = 1'b0;

    // Backpressure on lane b
    do_reset();
    out_ready  = 1'b0;
    in_valid_b = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_instr_b = 32'h2000_0000 + 32'(i);
      chk("t4_ready_fill", 32'(in_ready_b), 32'd1);
      step();
    end
    in_instr_b = 32'h2000_0006;
    chk("t4_ready_full", 32'(in_ready_b), 32'd0);
    chk("t4_stall_instr", out_instr, 32'h2000_0001);
    step();
    step();
    chk("t4_ready_still_full", 32'(in_ready_b), 32'd0);
    chk("t4_stall_hold", out_instr, 32'h2000_0001);
    chk("t4_stall_valid", 32'(out_valid), 32'd1);
    chk("t4_stall_count", retire_count, 32'd0);
    out_ready = 1'b1;
    step();
    chk("t4_beat2", out_instr, 32'h2000_0002);
    chk("t4_ready_rise", 32'(in_ready_b), 32'd1);
    chk("t4_count1", retire_count, 32'd1);
    step();
    in_valid_b = 1'b0;
    chk("t4_beat3", out_instr, 32'h2000_0003);
    step();
    chk("t4_beat4", out_instr, 32'h2000_0004);
    step();
    chk("t4_beat5", out_instr, 32'h2000_0005);
    step();
    chk("t4_beat6", out_instr, 32'h2000_0006);
    chk("t4_lane", 32'(out_lane), 32'd1);
    step();
    chk("t4_valid_end", 32'(out_valid), 32'd0);
    chk("t4_count6", retire_count, 32'd6);

    // Asynchronous reset mid-operation
    do_reset();
    out_ready  = 1'b0;
    in_valid_d = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_instr_d = 32'h6000_0000 + 32'(i);
      step();
    end
    in_instr_d = 32'h6000_0005;
    out_ready  = 1'b1;
    step();
    in_valid_d = 1'b0;
    out_ready  = 1'b0;
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    chk("t5_pre_instr", out_instr, 32'h6000_0002);
    chk("t5_pre_count", retire_count, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_count", retire_count, 32'd0);
    chk("t5_async_ready", 32'({in_ready_d, in_ready_c, in_ready_b, in_ready_a}), 32'hF);
    step();
    rst_n = 1'b1;
    chk("t5_rel_valid", 32'(out_valid), 32'd0);
    out_ready  = 1'b1;
    in_valid_a = 1'b1;
    in_instr_a = 32'h0000_00A5;
    step();
    in_valid_a = 1'b0;
    chk("t5_no_stale", 32'(out_valid), 32'd0);
    step();
    chk("t5_a_valid", 32'(out_valid), 32'd1);
    chk("t5_a_lane", 32'(out_lane), 32'd0);
    chk("t5_a_instr", out_instr, 32'h0000_00A5);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_idle", 32'(out_valid), 32'd0);
    end
    chk("t5_count", retire_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_retire_merger.md
Name: instr_retire_merger

Overview:
- Return path of the instruction scheduler.
- Collects completed instructions from the four execution streams (a, b, c, d).
- Buffers each stream in its own FIFO and merges them onto a single host-bound valid/ready stream using a round-robin arbiter.
- Tags each output beat with its source lane and counts retired instructions.

Parameters:
WIDTH, 32, instruction word width in bits
DEPTH, 4, entries per lane FIFO; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_a  input  1  lane a (opcode 0 unit) completion valid
in_ready_a  output  1  lane a FIFO can accept
in_instr_a  input  WIDTH  lane a completed instruction
in_valid_b / in_ready_b / in_instr_b  as lane a, for lane b (opcode 1)
in_valid_c / in_ready_c / in_instr_c  as lane a, for lane c (opcode 2)
in_valid_d / in_ready_d / in_instr_d  as lane a, for lane d (opcode 3)
out_valid  output  1  merged stream valid (registered)
out_ready  input  1  host accepts merged beat
out_instr  output  WIDTH  merged instruction (registered)
out_lane  output  2  source lane of out_instr: 0=a, 1=b, 2=c, 3=d
retire_count  output  32  number of beats accepted on the merged output; wraps modulo 2^32

Behaviour:
Reset:
- Asynchronous on rst_n low. All FIFOs emptied (pointers and counts 0).
- out_valid=0, out_instr=0, out_lane=0, retire_count=0.
- Arbiter last-grant pointer=3, so lane a has first priority.
- in_ready_x=1 once reset is released.
- Reset mid-operation discards all buffered and held instructions; nothing is replayed.

Input side, per lane x:
- in_ready_x = !full_x. It depends on FIFO state only, never combinationally on in_valid_x, out_ready, or a same-cycle pop.
- Push when in_valid_x && in_ready_x.
- A full FIFO that is popped in a cycle does not accept a push in that same cycle; in_ready_x rises the cycle after the pop.
- Push and pop on a non-full FIFO in the same cycle are both performed; the count is unchanged.
- Order within a lane is strictly FIFO.

Output register:
- Loads when (!out_valid || out_ready) and at least one FIFO is non-empty.
- Winner is chosen by round-robin: search lanes starting at last_grant+1 mod 4, first non-empty lane wins.
- On load: the winner's head entry is popped, out_instr=head, out_lane=winner, out_valid=1, last_grant=winner.
- If (!out_valid || out_ready) and all FIFOs are empty: out_valid goes to 0. out_instr and out_lane hold their last values.
- While out_valid && !out_ready: out_instr, out_lane and out_valid are held stable, and no pop occurs.
- No FIFO-to-output bypass. An instruction accepted at edge k is at the earliest presented with out_valid=1 after edge k+1.
- Throughput: one beat per cycle when out_ready is held high and data is available.

Counter:
- retire_count increments by 1 on each edge where out_valid && out_ready; 0xFFFF_FFFF wraps to 0.

Capacity:
- Each lane holds DEPTH entries in its FIFO, plus the one entry that may sit in the output register.

Test Plan:
1. Single beat, out_ready=1: lane c pushes 0x4000_0001 at edge 1 -> out_valid=1 after edge 2 with out_instr=0x4000_0001 and out_lane=2; out_valid=0 after edge 3; retire_count=1.
2. Simultaneous lanes, out_ready=1: a, b, c, d push 0x0000_000A, 0x2000_000B, 0x4000_000C, 0x6000_000D at the same edge -> beats on four consecutive cycles in order a, b, c, d (out_lane 0, 1, 2, 3); retire_count=4.
3. Fairness: lanes a and c continuously valid, out_ready=1 -> out_lane alternates 0, 2, 0, 2, ...; lanes b and d never granted.
4. Backpressure, DEPTH=4: out_ready=0, lane b offers 6 beats 0x2000_0001..0x2000_0006 -> first 5 accepted (1 in output register, 4 in FIFO) and in_ready_b=0 thereafter. out_instr stays 0x2000_0001 while stalled. Then raise out_ready -> 0x2000_0001..0x2000_0005 emerge in order; in_ready_b rises the cycle after the first FIFO pop; the 6th beat is then accepted and emerges last; retire_count=6.
5. Reset mid-operation: with 3 beats buffered in lane d and out_valid=1, pulse rst_n low asynchronously -> out_valid=0, retire_count=0 and all in_ready_x=1 immediately; after release no stale beat ever appears; next lane a push is granted first.
